fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Receiver of the redirect interface driven by the decode stage: branch, jump and jump-register requests.
- Owns the PC register, next-PC selection and instruction memory addressing.
- Presents pc/instruction/instruction-code to decode.
- Architectural branch delay slot: a taken redirect never flushes the fetched instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_AW, 12, word-address width presented to instruction memory.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit hold; freezes PC and IF/ID
- imem_addr  out  IMEM_AW  word address (pc_reg[IMEM_AW+1:2])
- imem_rdata  in  32  combinational instruction read data
- branch_in  in  1  decode: branch taken
- branch_offset  in  32  decode: sign-extended 16-bit immediate
- jump_in  in  1  decode: j/jal
- jump_index  in  26  decode: instr_index
- jump_reg_in  in  1  decode: jr
- jump_reg_target  in  32  decode: forwarded rs value
- if_pc  out  32  current fetch PC (pc_reg)
- id_pc  out  32  IF/ID registered PC
- id_instr  out  32  IF/ID registered instruction
- id_instr_code  out  6  IF/ID registered internal instruction code

Behaviour:
- Reset is synchronous, checked on the rising clk edge: pc_reg <= RESET_PC, id_pc <= RESET_PC, id_instr <= 32'h0 (NOP), id_instr_code <= CODE_NOP. Reset overrides stall and redirects.
- Fetch latency: imem_rdata is sampled in the same cycle imem_addr is driven. The instruction appears on id_* one cycle later.
- Redirect target computation uses id_pc, the PC of the control instruction currently in decode:
  - branch: id_pc + 4 + (branch_offset << 2), modulo 2^32.
  - jump: {id_pc_plus4[31:28], jump_index, 2'b00}, where id_pc_plus4 = id_pc + 4.
  - jump_reg: jump_reg_target, used as is. A misaligned target is not trapped; bits [1:0] are ignored by imem_addr.
- Next-PC priority: reset > stall (hold) > jump_reg_in > jump_in > branch_in > pc_reg + 4.
  - Simultaneous redirect requests are illegal from decode but resolved by this priority.
  - Wrap-around at 32'hFFFF_FFFC + 4 gives 0 and is not flagged.
- IF/ID update when not stalled: id_pc <= pc_reg, id_instr <= imem_rdata, id_instr_code <= classify(imem_rdata). A redirect does not clear IF/ID, because the delay-slot instruction proceeds.
- Stall: pc_reg, id_pc, id_instr and id_instr_code all hold. Redirect inputs are ignored while stall=1; decode re-asserts them once the stall releases, since its inputs are held.
- Reset mid-stall or mid-redirect: the reset values win in that cycle. The first post-reset fetch is RESET_PC.
- classify (combinational, 6-bit):
  - CODE_NOP for all-zero.
  - ADDU / SUBU / JR for SPECIAL funct 21/23/08.
  - ORI / LW / SW / BEQ / LUI / J / JAL for opcodes 0D/23/2B/04/0F/02/03.
  - CODE_UNKNOWN otherwise. Unknown codes still pass through.

Decomposition:
- Shared package holds:
  - the 6-bit CODE_* constants (shared with decode/control);
  - the opcode and funct constants;
  - NOP_INSTR;
  - the default RESET_PC.
- One sub-module, instr_classify: the pure combinational opcode/funct to code map, reusable by later stages.
- The PC register and the IF/ID register stay in fetch_stage.

Test Plan:
- Reset then 3 free cycles, imem returning 0x3421_0001 at each address:
  - if_pc sequence is 0x3000, 0x3004, 0x3008;
  - id_pc lags by one cycle;
  - id_instr_code is CODE_ORI.
- Branch redirect: branch_in=1 with id_pc=0x3008 and branch_offset=0xFFFF_FFFE:
  - next if_pc = 0x3004;
  - delay-slot instruction from 0x300C still appears on id_*.
- Jump and jump-register redirects:
  - jump_in=1, id_pc=0x3010, jump_index=26'h0000C05 gives if_pc 0x0000_3014;
  - jump_reg_in=1 with jump_reg_target=0x3100 gives if_pc 0x3100.
- Priority: jump_reg_in, jump_in and branch_in asserted together → jump_reg_target taken.
- Stall for 2 cycles with branch_in=1:
  - pc_reg and id_* hold;
  - the branch is applied on the first unstalled cycle.
- Reset asserted during stall with jump_in=1 → next state is if_pc=RESET_PC, id_instr=0, id_instr_code=CODE_NOP.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: internal instruction codes, MIPS opcode/funct
// fields, the NOP encoding and the default reset PC.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    localparam logic [5:0] CODE_NOP     = 6'd0;
    localparam logic [5:0] CODE_ADDU    = 6'd1;
    localparam logic [5:0] CODE_SUBU    = 6'd2;
    localparam logic [5:0] CODE_JR      = 6'd3;
    localparam logic [5:0] CODE_ORI     = 6'd4;
    localparam logic [5:0] CODE_LW      = 6'd5;
    localparam logic [5:0] CODE_SW      = 6'd6;
    localparam logic [5:0] CODE_BEQ     = 6'd7;
    localparam logic [5:0] CODE_LUI     = 6'd8;
    localparam logic [5:0] CODE_J       = 6'd9;
    localparam logic [5:0] CODE_JAL     = 6'd10;
    localparam logic [5:0] CODE_UNKNOWN = 6'h3F;

    typedef enum logic [2:0] {
        PC_SEL_SEQ,
        PC_SEL_BRANCH,
        PC_SEL_JUMP,
        PC_SEL_JR,
        PC_SEL_HOLD
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_instr_classify.sv
// Pure combinational map from a raw MIPS instruction word to the internal
// 6-bit instruction code consumed by decode/control.
module instr_classify
    import fetch_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_code
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];

    always_comb begin
        o_code = CODE_UNKNOWN;
        if (i_instr == NOP_INSTR) begin
            o_code = CODE_NOP;
        end else begin
            case (w_opcode)
                OP_SPECIAL: begin
                    case (w_funct)
                        FUNCT_ADDU: o_code = CODE_ADDU;
                        FUNCT_SUBU: o_code = CODE_SUBU;
                        FUNCT_JR:   o_code = CODE_JR;
                        default:    o_code = CODE_UNKNOWN;
                    endcase
                end
                OP_ORI:  o_code = CODE_ORI;
                OP_LW:   o_code = CODE_LW;
                OP_SW:   o_code = CODE_SW;
                OP_BEQ:  o_code = CODE_BEQ;
                OP_LUI:  o_code = CODE_LUI;
                OP_J:    o_code = CODE_J;
                OP_JAL:  o_code = CODE_JAL;
                default: o_code = CODE_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: PC, next-PC selection for decode redirects
// (delay slot preserved) and instruction memory addressing.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               branch_in,
    input  logic [31:0]        branch_offset,
    input  logic               jump_in,
    input  logic [25:0]        jump_index,
    input  logic               jump_reg_in,
    input  logic [31:0]        jump_reg_target,
    output logic [31:0]        if_pc,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_instr,
    output logic [5:0]         id_instr_code
);

    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic [5:0]  r_id_code;

    logic [31:0] w_id_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_next_pc;
    logic [5:0]  w_fetch_code;
    pc_sel_e     w_pc_sel;

    instr_classify u_classify (
        .i_instr (imem_rdata),
        .o_code  (w_fetch_code)
    );

    // Targets are relative to the control instruction now sitting in decode.
    assign w_id_pc_plus4   = r_id_pc + 32'd4;
    assign w_branch_target = w_id_pc_plus4 + {branch_offset[29:0], 2'b00};
    assign w_jump_target   = {w_id_pc_plus4[31:28], jump_index, 2'b00};

    always_comb begin
        w_pc_sel = PC_SEL_SEQ;
        if (stall)            w_pc_sel = PC_SEL_HOLD;
        else if (jump_reg_in) w_pc_sel = PC_SEL_JR;
        else if (jump_in)     w_pc_sel = PC_SEL_JUMP;
        else if (branch_in)   w_pc_sel = PC_SEL_BRANCH;
    end

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        case (w_pc_sel)
            PC_SEL_HOLD:   w_next_pc = r_pc;
            PC_SEL_JR:     w_next_pc = jump_reg_target;
            PC_SEL_JUMP:   w_next_pc = w_jump_target;
            PC_SEL_BRANCH: w_next_pc = w_branch_target;
            default:       w_next_pc = r_pc + 32'd4;
        endcase
    end

    // IF/ID is never cleared on redirect: the fetched word is the delay slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_id_pc    <= RESET_PC;
            r_id_instr <= NOP_INSTR;
            r_id_code  <= CODE_NOP;
        end else if (!stall) begin
            r_pc       <= w_next_pc;
            r_id_pc    <= r_pc;
            r_id_instr <= imem_rdata;
            r_id_code  <= w_fetch_code;
        end
    end

    assign imem_addr     = r_pc[IMEM_AW+1:2];
    assign if_pc         = r_pc;
    assign id_pc         = r_id_pc;
    assign id_instr      = r_id_instr;
    assign id_instr_code = r_id_code;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected post-edge state is queued when a
// step is driven and popped/compared half a cycle after the rising edge.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        logic [5:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_in = 1'b0;
    logic [31:0] branch_offset = 32'h0;
    logic        jump_in = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jump_reg_in = 1'b0;
    logic [31:0] jump_reg_target = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_instr_code;

    int          n_vec = 0;
    int          n_err = 0;
    int          mode = 0;
    logic [31:0] force_instr = 32'h0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    // mode 0: constant ORI; mode 1: LW tagged with its word address; mode 2: forced word
    always_comb begin
        imem_rdata = 32'h3421_0001;
        case (mode)
            1:       imem_rdata = 32'h8C00_0000 | {20'h0, imem_addr};
            2:       imem_rdata = force_instr;
            default: imem_rdata = 32'h3421_0001;
        endcase
    end

    fetch_stage #(.RESET_PC(32'h0000_3000), .IMEM_AW(12)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .branch_in       (branch_in),
        .branch_offset   (branch_offset),
        .jump_in         (jump_in),
        .jump_index      (jump_index),
        .jump_reg_in     (jump_reg_in),
        .jump_reg_target (jump_reg_target),
        .if_pc           (if_pc),
        .id_pc           (id_pc),
        .id_instr        (id_instr),
        .id_instr_code   (id_instr_code)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ipc,
                                input logic [31:0] ins, input logic [5:0] code);
        exp_t e;
        e.pc = pc; e.id_pc = ipc; e.id_instr = ins; e.code = code;
        return e;
    endfunction

    function automatic logic [31:0] lw_at(input logic [31:0] pc);
        return 32'h8C00_0000 | ((pc >> 2) & 32'h0000_0FFF);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive at negedge, let one rising edge pass, compare at the next negedge.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic br, input logic [31:0] boff,
                        input logic j, input logic [25:0] jidx,
                        input logic jr, input logic [31:0] jrt, input exp_t e);
        exp_t x;
        reset = rst; stall = st;
        branch_in = br; branch_offset = boff;
        jump_in = j; jump_index = jidx;
        jump_reg_in = jr; jump_reg_target = jrt;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        chk32({tag, ".if_pc"}, if_pc, x.pc);
        chk32({tag, ".id_pc"}, id_pc, x.id_pc);
        chk32({tag, ".id_instr"}, id_instr, x.id_instr);
        chk32({tag, ".code"}, {26'h0, id_instr_code}, {26'h0, x.code});
        chk32({tag, ".imem_addr"}, {20'h0, imem_addr}, {20'h0, x.pc[13:2]});
    endtask

    logic [31:0] cls_instr [10] = '{32'h0022_1821, 32'h0022_1823, 32'h03E0_0008,
                                    32'hAC00_0000, 32'h1000_0000, 32'h3C01_0000,
                                    32'h0800_0000, 32'h0C00_0000, 32'h0000_0001,
                                    32'hFC00_0000};
    logic [5:0]  cls_code  [10] = '{CODE_ADDU, CODE_SUBU, CODE_JR, CODE_SW, CODE_BEQ,
                                    CODE_LUI, CODE_J, CODE_JAL, CODE_UNKNOWN,
                                    CODE_UNKNOWN};

    initial begin
        logic [31:0] last;
        @(negedge clk);
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, mk(32'h3000, 32'h3000, 32'h0, CODE_NOP));
        step("free1", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h3004, 32'h3000, 32'h3421_0001, CODE_ORI));
        step("free2", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h3008, 32'h3004, 32'h3421_0001, CODE_ORI));
        mode = 1;
        step("free3", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h300C, 32'h3008, lw_at(32'h3008), CODE_LW));
        step("branch", 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0,
             mk(32'h3004, 32'h300C, lw_at(32'h300C), CODE_LW));
        step("after_br", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h3008, 32'h3004, lw_at(32'h3004), CODE_LW));
        step("seq_a", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h300C, 32'h3008, lw_at(32'h3008), CODE_LW));
        step("seq_b", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h3010, 32'h300C, lw_at(32'h300C), CODE_LW));
        step("seq_c", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h3014, 32'h3010, lw_at(32'h3010), CODE_LW));
        step("jump", 0, 0, 0, 0, 1, 26'h0000C05, 0, 0,
             mk(32'h3014, 32'h3014, lw_at(32'h3014), CODE_LW));
        step("jreg", 0, 0, 0, 0, 0, 0, 1, 32'h3100,
             mk(32'h3100, 32'h3014, lw_at(32'h3014), CODE_LW));
        step("prio", 0, 0, 1, 32'h5, 1, 26'h1234, 1, 32'h3200,
             mk(32'h3200, 32'h3100, lw_at(32'h3100), CODE_LW));
        step("stall1", 0, 1, 1, 32'h4, 0, 0, 0, 0, mk(32'h3200, 32'h3100, lw_at(32'h3100), CODE_LW));
        step("stall2", 0, 1, 1, 32'h4, 0, 0, 0, 0, mk(32'h3200, 32'h3100, lw_at(32'h3100), CODE_LW));
        step("unstall_br", 0, 0, 1, 32'h4, 0, 0, 0, 0,
             mk(32'h3114, 32'h3200, lw_at(32'h3200), CODE_LW));
        step("rst_in_stall", 1, 1, 0, 0, 1, 26'h0000C05, 0, 0,
             mk(32'h3000, 32'h3000, 32'h0, CODE_NOP));
        step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, mk(32'h3004, 32'h3000, lw_at(32'h3000), CODE_LW));

        mode = 2;
        last = 32'h3004;
        for (int k = 0; k < 10; k++) begin
            force_instr = cls_instr[k];
            step($sformatf("cls%0d", k), 0, 0, 0, 0, 0, 0, 0, 0,
                 mk(last + 32'd4, last, cls_instr[k], cls_code[k]));
            last = last + 32'd4;
        end

        step("jr_top", 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC,
             mk(32'hFFFF_FFFC, last, force_instr, CODE_UNKNOWN));
        step("wrap", 0, 0, 0, 0, 0, 0, 0, 0,
             mk(32'h0000_0000, 32'hFFFF_FFFC, force_instr, CODE_UNKNOWN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
